line_scan_clkgen: RTL and testbench

Parametrised multi-channel clock generator for the line-scan camera path. It is driven by the 50 MHz `refclk` and produces `NUM_CLOCKS` phase-aligned divided clock outputs. Each output has its own run-time divide, duty and phase, set through a valid/ready config port. A `locked` flag indicates settled, aligned outputs. It sits between the SoC fabric clock and the camera CLK/SI drivers, and it makes camera clock rates software-programmable.

---
 rtl/line_scan_clkgen_pkg.sv | 43 ++++
 rtl/line_scan_clkgen_chan.sv | 83 ++++++++
 rtl/line_scan_clkgen.sv | 131 +++++++++++++
 tb/tb_line_scan_clkgen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/line_scan_clkgen_pkg.sv
// line_scan_clkgen_pkg: shared types, reset defaults and config clamp helpers
// for the line-scan camera clock generator.
package line_scan_clkgen_pkg;

  // Alignment state machine: ALIGN restarts every channel counter together,
  // SETTLE waits for the outputs to settle, LOCKED is steady operation.
  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Power-up channel settings: refclk/2 at 50% duty, no phase offset.
  localparam int unsigned DEF_DIV   = 2;
  localparam int unsigned DEF_HIGH  = 1;
  localparam int unsigned DEF_PHASE = 0;

  // The clamp helpers work on 32-bit values; callers zero-extend the
  // CNT_W-wide config fields and truncate the result back.
  // A period shorter than two cycles cannot produce a toggling clock.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div < 32'd2) ? 32'd2 : div;
  endfunction

  // High time must leave at least one low cycle and be at least one cycle.
  // div_c is the already-clamped period.
  function automatic logic [31:0] clamp_high(input logic [31:0] div_c,
                                             input logic [31:0] high);
    if (high == 32'd0) begin
      return 32'd1;
    end else if (high >= div_c) begin
      return div_c - 32'd1;
    end
    return high;
  endfunction

  // A start offset outside the period falls back to zero.
  function automatic logic [31:0] clamp_phase(input logic [31:0] div_c,
                                              input logic [31:0] phase);
    return (phase >= div_c) ? 32'd0 : phase;
  endfunction

endpackage

// File: rtl/line_scan_clkgen_chan.sv
// line_scan_clkgen_chan: one divided-clock channel. Holds the channel's
// div/high (and, with LSCLK_PHASE_EN, phase) registers and its free-running
// counter. While align is high the counter is reloaded and the outputs held low.
module line_scan_clkgen_chan
  import line_scan_clkgen_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             align,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             outclk,
  output logic             outclk_rise
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] high;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] align_cnt;
  logic             level;

`ifdef LSCLK_PHASE_EN
  logic [CNT_W-1:0] phase;

  // Phase register: the count value loaded when the channel realigns.
  always_ff @(posedge refclk) begin
    if (rst) begin
      phase <= CNT_W'(DEF_PHASE);
    end else if (wr_en) begin
      phase <= wr_phase;
    end
  end

  assign align_cnt = phase;
`else
  // Without phase support every channel realigns to count zero.
  logic unused_phase;
  assign unused_phase = ^wr_phase;
  assign align_cnt    = '0;
`endif

  // Period / high-time registers, written only on an accepted config.
  always_ff @(posedge refclk) begin
    if (rst) begin
      div  <= CNT_W'(DEF_DIV);
      high <= CNT_W'(DEF_HIGH);
    end else if (wr_en) begin
      div  <= wr_div;
      high <= wr_high;
    end
  end

  // Counter wrap and output level. The level registered on an edge is the
  // one for the count being left, so a channel aligned to count p shows
  // (p < high) on the first edge after ALIGN.
  always_comb begin
    cnt_next = (cnt == div - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);
    level    = (cnt < high);
  end

  // Counter and registered outputs; rise strobe marks a 0->1 outclk step.
  always_ff @(posedge refclk) begin
    if (rst) begin
      cnt         <= '0;
      outclk      <= 1'b0;
      outclk_rise <= 1'b0;
    end else if (align) begin
      cnt         <= align_cnt;
      outclk      <= 1'b0;
      outclk_rise <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      outclk      <= level;
      outclk_rise <= level & ~outclk;
    end
  end

endmodule

// File: rtl/line_scan_clkgen.sv
// line_scan_clkgen: NUM_CLOCKS phase-aligned divided clocks from refclk with
// run-time divide/duty (and phase when LSCLK_PHASE_EN is defined), a
// valid/ready config port and a locked flag.
//
// Config handshake: a transfer happens on a refclk edge where
// cfg_valid & cfg_ready are both high. cfg_ready is high only in SETTLE and
// LOCKED and never while rst is asserted; the source must hold cfg_chan,
// cfg_div, cfg_high and cfg_phase stable while cfg_valid is high and
// cfg_ready is low.
module line_scan_clkgen
  import line_scan_clkgen_pkg::*;
#(
  parameter int  NUM_CLOCKS  = 2,
  parameter int  CNT_W       = 16,
  parameter int  LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_chan,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_high,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_rise,
  output logic                  locked
);

  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_e           state;
  state_e           state_next;
  logic [SET_W-1:0] settle_cnt;
  logic             settle_done;
  logic             accept;
  logic             align;
  logic             chan_bad;
  logic             err_pend;
  logic [CNT_W-1:0] c_div;
  logic [CNT_W-1:0] c_high;
  logic [CNT_W-1:0] c_phase;
  logic             c_err;

  assign settle_done = (settle_cnt == SET_W'(LOCK_CYCLES - 1));

  // State register; reset parks the FSM in ALIGN.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= ALIGN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: any accepted config sends every channel back through ALIGN.
  always_comb begin
    state_next = state;
    case (state)
      ALIGN:   state_next = SETTLE;
      SETTLE:  if (accept) state_next = ALIGN;
               else if (settle_done) state_next = LOCKED;
      LOCKED:  if (accept) state_next = ALIGN;
      default: state_next = ALIGN;
    endcase
  end

  // FSM outputs: handshake readiness and the channel realign strobe.
  always_comb begin
    cfg_ready = ~rst & ((state == SETTLE) | (state == LOCKED));
    align     = (state == ALIGN);
    accept    = cfg_valid & cfg_ready;
  end

  // Clamp the incoming config; any altered field flags an error. An
  // out-of-range phase only counts when phase registers exist.
  always_comb begin
    c_div    = CNT_W'(clamp_div(32'(cfg_div)));
    c_high   = CNT_W'(clamp_high(32'(c_div), 32'(cfg_high)));
    c_phase  = CNT_W'(clamp_phase(32'(c_div), 32'(cfg_phase)));
    chan_bad = (32'(cfg_chan) >= 32'(NUM_CLOCKS));
`ifdef LSCLK_PHASE_EN
    c_err = (c_div != cfg_div) | (c_high != cfg_high) | (c_phase != cfg_phase);
`else
    c_err = (c_div != cfg_div) | (c_high != cfg_high);
`endif
  end

  // Settle counter, locked flag and the error pulse (one cycle after accept).
  always_ff @(posedge refclk) begin
    if (rst) begin
      settle_cnt <= '0;
      locked     <= 1'b0;
      err_pend   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      err_pend <= accept & (c_err | chan_bad);
      cfg_err  <= err_pend;
      if (state == ALIGN) begin
        settle_cnt <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end
      if (accept) begin
        locked <= 1'b0;
      end else if ((state == SETTLE) && settle_done) begin
        locked <= 1'b1;
      end
    end
  end

  // One channel per output; a write only lands on a valid channel number.
  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    line_scan_clkgen_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .refclk      (refclk),
      .rst         (rst),
      .align       (align),
      .wr_en       (accept && (cfg_chan == CH_W'(i))),
      .wr_div      (c_div),
      .wr_high     (c_high),
      .wr_phase    (c_phase),
      .outclk      (outclk[i]),
      .outclk_rise (outclk_rise[i])
    );
  end

endmodule

// File: tb/tb_line_scan_clkgen.sv
// tb_line_scan_clkgen: directed + random config traffic against a cycle
// reference model; per-edge expectations go through a queue to a monitor.
module tb_line_scan_clkgen;

  localparam int N    = 3;
  localparam int CW   = 16;
  localparam int LC   = 16;
  localparam int CH_W = 2;
  localparam int EW   = 3 + 2 * N;
`ifdef LSCLK_PHASE_EN
  localparam bit PHASE_EN = 1'b1;
`else
  localparam bit PHASE_EN = 1'b0;
`endif

  logic            refclk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_chan = '0;
  logic [CW-1:0]   cfg_div = '0;
  logic [CW-1:0]   cfg_high = '0;
  logic [CW-1:0]   cfg_phase = '0;
  logic            cfg_err;
  logic [N-1:0]    outclk;
  logic [N-1:0]    outclk_rise;
  logic            locked;

  int n_checks = 0;
  int n_fail   = 0;

  line_scan_clkgen #(.NUM_CLOCKS(N), .CNT_W(CW), .LOCK_CYCLES(LC)) dut (
    .refclk      (refclk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_phase   (cfg_phase),
    .cfg_err     (cfg_err),
    .outclk      (outclk),
    .outclk_rise (outclk_rise),
    .locked      (locked)
  );

  // Clock / watchdog
  always #10 refclk = ~refclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channel waveform at k edges after ALIGN is
  // ((phase + k - 1) mod div) < high; locked after LC edges past ALIGN.
  logic [EW-1:0] exp_q[$];
  int   m_div[N];
  int   m_high[N];
  int   m_phase[N];
  bit   m_align_next, m_locked, m_ready, m_err_pend, m_err;
  int   m_k;
  logic [N-1:0] m_out, m_rise;

  always @(posedge refclk) begin
    bit acc;
    logic [N-1:0] nout;
    int ch, d, h, p, nd, nh, np;
    bit e;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_div[i] = 2; m_high[i] = 1; m_phase[i] = 0;
      end
      m_align_next = 1; m_locked = 0; m_ready = 0;
      m_err_pend = 0; m_err = 0; m_out = '0; m_rise = '0; m_k = 0;
    end else begin
      acc = cfg_valid && m_ready;
      m_err = m_err_pend;
      m_err_pend = 0;
      if (m_align_next) begin
        m_align_next = 0; m_k = 0; m_out = '0; m_rise = '0; m_ready = 1;
      end else begin
        m_k++;
        for (int i = 0; i < N; i++)
          nout[i] = ((m_phase[i] + m_k - 1) % m_div[i]) < m_high[i];
        m_rise = nout & ~m_out;
        m_out = nout;
        if (m_k == LC) m_locked = 1;
        if (acc) begin
          ch = int'(cfg_chan); d = int'(cfg_div); h = int'(cfg_high); p = int'(cfg_phase);
          nd = (d < 2) ? 2 : d;
          nh = (h == 0) ? 1 : ((h >= nd) ? nd - 1 : h);
          np = (PHASE_EN && p < nd) ? p : 0;
          e = (d < 2) || (h == 0) || (h >= nd) || (PHASE_EN && p >= nd) || (ch >= N);
          if (ch < N) begin
            m_div[ch] = nd; m_high[ch] = nh; m_phase[ch] = np;
          end
          m_err_pend = e;
          m_locked = 0; m_align_next = 1; m_ready = 0;
        end
      end
    end
    exp_q.push_back({m_locked, m_ready, m_err, m_out, m_rise});
  end

  // Monitor: one expected entry per edge, compared mid-cycle.
  always @(negedge refclk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("locked", 32'(locked), 32'(e[EW-1]));
      chk("cfg_ready", 32'(cfg_ready), 32'(e[EW-2] & ~rst));
      chk("cfg_err", 32'(cfg_err), 32'(e[EW-3]));
      chk("outclk", 32'(outclk), 32'(e[2*N-1:N]));
      chk("outclk_rise", 32'(outclk_rise), 32'(e[N-1:0]));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge refclk);
    #2;
  endtask

  task automatic idle(input int n);
    cfg_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input int ch, input int d, input int h, input int p);
    int n = 0;
    cfg_valid = 1'b1;
    cfg_chan  = CH_W'(ch);
    cfg_div   = CW'(d);
    cfg_high  = CW'(h);
    cfg_phase = CW'(p);
    forever begin
      @(negedge refclk);
      if (cfg_ready) break;
      n++;
      if (n > 64) begin
        n_checks++; n_fail++;
        $display("FAIL handshake_timeout: cfg_ready low for %0d cycles, required high", n);
        break;
      end
    end
    tick();
  endtask

  // Edges from now until locked is seen; must equal 1 + LC.
  task automatic wait_locked(input string name);
    int n = 0;
    cfg_valid = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (locked) break;
    end
    chk(name, 32'(n), 32'(1 + LC));
  endtask

  // Stimulus
  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_locked("lock_after_reset");
    idle(8);

    send(0, 5, 2, 0);
    wait_locked("lock_after_ch0_write");
    idle(12);

    send(1, 4, 1, 2);
    wait_locked("lock_after_ch1_phase");
    idle(12);

    send(0, 1, 7, 9);
    idle(24);

    send(1, 3, 1, 1);
    idle(5);
    send(0, 6, 3, 1);
    wait_locked("lock_after_settle_rewrite");

    send(1, 7, 3, 5);
    send(0, 4, 4, 0);
    idle(24);

    send(3, 9, 2, 1);
    idle(24);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_locked("lock_after_mid_reset");
    idle(6);

    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, 3), $urandom_range(0, 10),
           $urandom_range(0, 10), $urandom_range(0, 10));
      idle($urandom_range(0, 25));
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
